// File: rtl/half_max_pool_ctrl.sv
// half_max_pool_ctrl
// Reduces a window of LEN fp16 samples to its maximum value and the index of
// that maximum. It does this by time-sharing one external registered half_max
// comparator, which has a 1-cycle latency.
// The controller owns the comparator operand registers (max_a/max_b) and the
// comparator reset (max_rstn), and it captures the comparator result (max_c).
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   clear               synchronous abort of the current window
//   in_valid/in_ready   upstream sample handshake, in_data = fp16 sample
//   max_rstn            active-low reset to the comparator (= ~rst)
//   max_a, max_b        comparator operands: running max, held sample
//   max_c               comparator result, valid one cycle after the operands
//   out_valid/out_ready downstream result handshake
//   out_data, out_idx   window maximum and its position 0..LEN-1
module half_max_pool_ctrl #(
   parameter int LEN   = 16,
   parameter int IDX_W = (LEN > 1) ? $clog2(LEN) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_data,
   output logic             max_rstn,
   output logic [15:0]      max_a,
   output logic [15:0]      max_b,
   input  logic [15:0]      max_c,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      out_data,
   output logic [IDX_W-1:0] out_idx
);

   localparam int DATA_W = 16;
   // One extra bit so that a power-of-two LEN can count up to LEN without wrapping.
   localparam int CNT_W  = IDX_W + 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   typedef enum logic [1:0] {ACCEPT, CMP, CAP, DONE} state_t;

   state_t state;
   state_t state_next;

   logic [DATA_W-1:0] acc;
   logic [DATA_W-1:0] b_reg;
   logic [CNT_W-1:0]  cnt;
   logic [IDX_W-1:0]  idx;
   logic              accept_state;
   logic              new_max;

   assign max_rstn = ~rst;
   assign max_a    = acc;
   assign max_b    = b_reg;

   // A bitwise change of the running max means the current sample won the compare.
   // Ties return the running max unchanged, so the earliest index is kept.
   assign new_max  = (max_c != acc);

   // During rst the state already reads ACCEPT, so rst has to gate in_ready explicitly.
   assign in_ready = accept_state & ~rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ACCEPT;
      else     state <= state_next;
   end

   always_comb begin
      state_next   = state;
      accept_state = 1'b0;
      case (state)
         ACCEPT: begin
            accept_state = 1'b1;
            if (in_valid) begin
               if (cnt == '0) begin
                  if (LEN == 1) state_next = DONE;
               end else begin
                  state_next = CMP;
               end
            end
         end
         // The comparator samples max_a/max_b at the edge that closes this state.
         CMP:     state_next = CAP;
         CAP:     state_next = (cnt == LAST) ? DONE : ACCEPT;
         DONE:    if (out_ready) state_next = ACCEPT;
         default: state_next = ACCEPT;
      endcase
      if (clear) state_next = ACCEPT;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc       <= '0;
         b_reg     <= '0;
         cnt       <= '0;
         idx       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_idx   <= '0;
      end else if (clear) begin
         // Abort: any sample offered this cycle is dropped.
         // The next window restarts at cnt 0.
         cnt       <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            ACCEPT: begin
               if (in_valid) begin
                  if (cnt == '0) begin
                     acc <= in_data;
                     idx <= '0;
                     cnt <= ONE;
                     if (LEN == 1) begin
                        out_valid <= 1'b1;
                        out_data  <= in_data;
                        out_idx   <= '0;
                     end
                  end else begin
                     b_reg <= in_data;
                  end
               end
            end
            CAP: begin
               acc <= max_c;
               if (new_max) idx <= cnt[IDX_W-1:0];
               cnt <= cnt + ONE;
               if (cnt == LAST) begin
                  out_valid <= 1'b1;
                  out_data  <= max_c;
                  out_idx   <= new_max ? cnt[IDX_W-1:0] : idx;
               end
            end
            DONE: begin
               if (out_ready) begin
                  cnt       <= '0;
                  out_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_half_max_pool_ctrl.sv
// Testbench for half_max_pool_ctrl.
// It checks a LEN=4 instance and a LEN=1 instance.
// Each instance drives a behavioural registered half_max comparator.
module tb_half_max_pool_ctrl;

   localparam int IDX = 2;

   logic clk = 1'b0;
   logic rst, clear;
   logic in_valid, in_ready, out_valid, out_ready, max_rstn;
   logic [15:0] in_data, max_a, max_b, max_c, out_data;
   logic [IDX-1:0] out_idx;

   logic in_valid1, in_ready1, out_valid1, out_ready1, max_rstn1;
   logic [15:0] in_data1, max_a1, max_b1, max_c1, out_data1;
   logic [0:0] out_idx1;

   int errors = 0;
   int checks = 0;
   logic [15:0] win [4];

   always #5 clk = ~clk;

   half_max_pool_ctrl #(.LEN(4)) dut (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .max_rstn(max_rstn), .max_a(max_a), .max_b(max_b), .max_c(max_c),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx));

   half_max_pool_ctrl #(.LEN(1)) dut1 (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid1), .in_ready(in_ready1),
      .in_data(in_data1), .max_rstn(max_rstn1), .max_a(max_a1), .max_b(max_b1), .max_c(max_c1),
      .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1), .out_idx(out_idx1));

   // fp16 ordering key: a larger key means a larger number, and +0 ranks above -0.
   function automatic logic [15:0] fkey(input logic [15:0] v);
      return v[15] ? ~v : (v | 16'h8000);
   endfunction

   function automatic logic [15:0] fmax(input logic [15:0] a, input logic [15:0] b);
      return (fkey(b) > fkey(a)) ? b : a;
   endfunction

   // External registered comparator models.
   always @(posedge clk or negedge max_rstn)
      if (!max_rstn) max_c <= '0; else max_c <= fmax(max_a, max_b);
   always @(posedge clk or negedge max_rstn1)
      if (!max_rstn1) max_c1 <= '0; else max_c1 <= fmax(max_a1, max_b1);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference: the maximum is the sample with the greatest key.
   // Its index is the first position holding exactly those bits.
   task automatic model(output logic [15:0] m, output int mi);
      m = win[0];
      for (int i = 1; i < 4; i++) if (fkey(win[i]) > fkey(m)) m = win[i];
      mi = 0;
      for (int i = 3; i >= 0; i--) if (win[i] == m) mi = i;
   endtask

   function automatic logic [15:0] rand_half();
      logic [15:0] v;
      logic [15:0] pick [4];
      pick[0] = 16'h3C00; pick[1] = 16'hBC00; pick[2] = 16'h0000; pick[3] = 16'h8000;
      if ($urandom_range(0, 2) == 0) v = pick[$urandom_range(0, 3)];
      else v = 16'($urandom);
      if (v[14:10] == 5'h1F) v[9:0] = '0;  // keep away from NaN
      return v;
   endfunction

   // Starts and ends at a negedge.
   task automatic send(input logic [15:0] d, output bit ok);
      ok = 1'b0;
      in_valid = 1'b1;
      in_data = d;
      for (int k = 0; k < 50; k++) begin
         if (in_ready) begin
            @(posedge clk);
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (ok) @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic run_window(input string tag, input int hold);
      logic [15:0] em;
      int ei, lat;
      bit ok;
      model(em, ei);
      for (int i = 0; i < 4; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         send(win[i], ok);
         chk({tag, "_hs"}, 32'(ok), 32'd1);
      end
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, "_lat"}, lat, 3);
      chk({tag, "_data"}, out_data, em);
      chk({tag, "_idx"}, 32'(out_idx), 32'(ei));
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk({tag, "_hold"}, {out_valid, in_ready, out_data, out_idx},
             {1'b1, 1'b0, em, IDX'(ei)});
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_drop"}, {out_valid, in_ready}, 2'b01);
   endtask

   initial begin
      bit ok;
      logic [15:0] v;
      rst = 1'b1; clear = 1'b0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_state", {in_ready, out_valid, out_data, out_idx, max_a, max_b, max_rstn},
          {1'b0, 1'b0, 16'h0, 2'b0, 16'h0, 16'h0, 1'b0});
      rst = 1'b0;
      #1 chk("rst_release_ready", in_ready, 1'b1);
      @(negedge clk);

      win[0] = 16'h3C00; win[1] = 16'h4000; win[2] = 16'h3800; win[3] = 16'hBC00;
      run_window("basic", 0);
      chk("basic_ref", out_data, 16'h4000);
      win[0] = 16'hC000; win[1] = 16'hBC00; win[2] = 16'hC200; win[3] = 16'hC400;
      run_window("neg", 10);
      win[0] = 16'h3C00; win[1] = 16'h3C00; win[2] = 16'h3800; win[3] = 16'h3C00;
      run_window("tie", 0);
      win[0] = 16'h8000; win[1] = 16'h0000; win[2] = 16'h8000; win[3] = 16'h0000;
      run_window("zero", 2);

      // rst in the middle of a window
      win[0] = 16'h5000; win[1] = 16'h6000;
      send(win[0], ok);
      send(win[1], ok);
      rst = 1'b1;
      #1 chk("midrst", {in_ready, out_valid, max_a, max_b, max_rstn}, {2'b00, 32'h0, 1'b0});
      @(negedge clk);
      rst = 1'b0;
      win[0] = 16'h7BFF; win[1] = 16'h0; win[2] = 16'h0; win[3] = 16'h0;
      run_window("after_rst", 0);

      // clear in the middle of a window, with a sample offered in the same cycle
      win[0] = 16'h5000; win[1] = 16'h6000;
      send(win[0], ok);
      send(win[1], ok);
      repeat (2) @(negedge clk);
      chk("clr_ready", in_ready, 1'b1);
      clear = 1'b1; in_valid = 1'b1; in_data = 16'h7C00;
      @(negedge clk);
      clear = 1'b0; in_valid = 1'b0;
      chk("clr_outv", out_valid, 1'b0);
      win[0] = 16'h7BFF; win[1] = 16'h0; win[2] = 16'h0; win[3] = 16'h0;
      run_window("after_clr", 0);

      for (int w = 0; w < 20; w++) begin
         for (int i = 0; i < 4; i++) win[i] = rand_half();
         run_window("rand", $urandom_range(0, 3));
      end

      // LEN=1: every handshake goes straight to DONE.
      for (int s = 0; s < 4; s++) begin
         v = rand_half();
         in_valid1 = 1'b1; in_data1 = v;
         chk("len1_ready", in_ready1, 1'b1);
         @(posedge clk);
         @(negedge clk);
         in_valid1 = 1'b0;
         chk("len1_out", {out_valid1, in_ready1, out_data1, out_idx1, max_b1},
             {1'b1, 1'b0, v, 1'b0, 16'h0});
         out_ready1 = 1'b1;
         @(posedge clk);
         @(negedge clk);
         out_ready1 = 1'b0;
         chk("len1_drop", out_valid1, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
